// File: rtl/dmem_bus_responder_if.sv
// CPU data-port bus between the load/store unit and the data-memory responder.
interface dmem_bus_responder_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/dmem_bus_responder.sv
// Data-memory slave: byte/half/word loads and stores with wait states,
// sign/zero extension and rejection of misaligned or out-of-range accesses.
module dmem_bus_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h10010000,
  parameter int unsigned DEPTH_WORDS = 2048,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 clk_in,
  input  logic                 reset,
  dmem_bus_responder_if.slave  bus
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic        we_q, sign_ext_q, err_q;
  logic [1:0]  size_q, lane_q;
  logic [AW-1:0] idx_q;
  logic [31:0] wdata_q, rdata_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] offset;
  logic        bad_req, accept;
  logic [4:0]  shamt;
  logic [31:0] cur_word, lane_mask, store_word, shifted, load_word;

  assign offset = bus.addr - BASE_ADDR;
  assign accept = bus.req && (state == S_IDLE || state == S_RESP);

  always_comb begin
    bad_req = 1'b0;
    unique case (bus.size)
      2'b00:   bad_req = 1'b0;
      2'b01:   bad_req = bus.addr[0];
      2'b10:   bad_req = (bus.addr[1:0] != 2'b00);
      default: bad_req = 1'b1;
    endcase
    if (bus.addr < BASE_ADDR || offset >= SPAN) bad_req = 1'b1;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_RESP: begin
        if (!bus.req)               state_nxt = S_IDLE;
        else if (bad_req)           state_nxt = S_RESP;
        else if (WAIT_LOAD == 4'd0) state_nxt = S_ACCESS;
        else                        state_nxt = S_WAIT;
      end
      S_WAIT:   if (wait_cnt == 4'd1) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_RESP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state == S_RESP);
    bus.err   = (state == S_RESP) && err_q;
    bus.busy  = (state != S_IDLE);
    bus.rdata = rdata_q;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wait_cnt   <= '0;
      we_q       <= 1'b0;
      sign_ext_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= '0;
      lane_q     <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
    end else if (accept) begin
      wait_cnt   <= WAIT_LOAD;
      we_q       <= bus.we;
      sign_ext_q <= bus.sign_ext;
      err_q      <= bad_req;
      size_q     <= bus.size;
      lane_q     <= bus.addr[1:0];
      idx_q      <= offset[AW+1:2];
      wdata_q    <= bus.wdata;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Lane position: halves move in 16-bit steps, bytes in 8-bit steps; words have lane 0.
  always_comb begin
    cur_word  = mem[idx_q];
    shamt     = (size_q == 2'b01) ? {lane_q[1], 4'b0000} : {lane_q, 3'b000};
    unique case (size_q)
      2'b00:   lane_mask = 32'h0000_00FF;
      2'b01:   lane_mask = 32'h0000_FFFF;
      default: lane_mask = '1;
    endcase
    lane_mask  = lane_mask << shamt;
    store_word = (cur_word & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    shifted    = cur_word >> shamt;
    unique case (size_q)
      2'b00:   load_word = {{24{sign_ext_q & shifted[7]}},  shifted[7:0]};
      2'b01:   load_word = {{16{sign_ext_q & shifted[15]}}, shifted[15:0]};
      default: load_word = shifted;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (state == S_ACCESS && we_q) mem[idx_q] <= store_word;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)                           rdata_q <= '0;
    else if (state == S_ACCESS && !we_q) rdata_q <= load_word;
  end

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Self-checking bench for dmem_bus_responder: randomized loads/stores against a
// byte-level memory model, per-cycle output comparison and directed corner cases.
module tb_dmem_bus_responder;

  localparam logic [31:0] BASE = 32'h10010000;
  localparam int          WAIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_bus_responder_if bus ();
  dmem_bus_responder_if bus0 ();

  dmem_bus_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(2048), .WAIT_CYCLES(WAIT)) u_dut (
    .clk_in(clk), .reset(rst), .bus(bus.slave)
  );
  dmem_bus_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(2048), .WAIT_CYCLES(0)) u_dut0 (
    .clk_in(clk), .reset(rst), .bus(bus0.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Expected timeline of the transaction in flight, as edge numbers.
  int          acc_edge  = -1;
  int          resp_edge = -1;
  bit          txn_err   = 1'b0;
  logic [31:0] rd_before = '0;
  logic [31:0] rd_after  = '0;

  logic [31:0] exp_rd;
  bit          exp_busy, exp_ready;
  always @(negedge clk) begin
    exp_busy  = (acc_edge >= 0) && (cyc >= acc_edge) && (cyc <= resp_edge);
    exp_ready = (cyc == resp_edge);
    exp_rd    = (resp_edge >= 0 && cyc >= resp_edge) ? rd_after : rd_before;
    chk("busy",  {31'b0, bus.busy},  {31'b0, exp_busy});
    chk("ready", {31'b0, bus.ready}, {31'b0, exp_ready});
    chk("err",   {31'b0, bus.err},   {31'b0, exp_ready & txn_err});
    chk("rdata", bus.rdata, exp_rd);
  end

  logic [31:0] mm [int];

  task automatic model_access(input bit w, input logic [1:0] sz, input bit sx,
                              input logic [31:0] a, input logic [31:0] wd,
                              input bit commit, output bit e, output int lat,
                              output logic [31:0] rd);
    int unsigned n, o, idx;
    logic [31:0] word, v;
    n  = 1 << sz;
    e  = (sz == 2'b11) || (a < BASE) || ((a - BASE) >= 32'd8192) || ((a % n) != 0);
    rd = rd_after;
    if (e) begin
      lat = 1;
    end else begin
      lat  = WAIT + 2;
      idx  = (a - BASE) / 4;
      o    = a % 4;
      word = mm.exists(int'(idx)) ? mm[int'(idx)] : 32'h0;
      if (w) begin
        for (int unsigned j = 0; j < n; j++) word[8*(o+j) +: 8] = wd[8*j +: 8];
        if (commit) mm[int'(idx)] = word;
      end else begin
        v = '0;
        for (int unsigned j = 0; j < n; j++) v[8*j +: 8] = word[8*(o+j) +: 8];
        if (sx && n < 4 && v[8*n-1])
          for (int unsigned j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
        rd = v;
      end
    end
  endtask

  task automatic junk();
    bus.req      = 1'($urandom_range(0, 1));
    bus.we       = 1'($urandom_range(0, 1));
    bus.size     = 2'($urandom_range(0, 3));
    bus.sign_ext = 1'($urandom_range(0, 1));
    bus.addr     = $urandom;
    bus.wdata    = $urandom;
  endtask

  task automatic do_txn(input bit w, input logic [1:0] sz, input bit sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output bit e);
    int lat;
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx;
    bus.addr = a; bus.wdata = wd;
    @(posedge clk); #1;
    model_access(w, sz, sx, a, wd, 1'b1, e, lat, rd);
    rd_before = rd_after;
    rd_after  = rd;
    txn_err   = e;
    acc_edge  = cyc;
    resp_edge = cyc + lat - 1;
    while (cyc < resp_edge) begin
      @(negedge clk); junk();
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); bus.req = 1'b0;
    end
  endtask

  logic [31:0] init_val [16];
  logic [31:0] rd;
  bit          e;
  logic [31:0] a;
  int          lat_chk;

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b10; bus.sign_ext = 1'b0;
    bus.addr = BASE; bus.wdata = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.size = 2'b10; bus0.sign_ext = 1'b0;
    bus0.addr = BASE; bus0.wdata = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset rdata", bus.rdata, 32'h0);
    chk("reset busy", {31'b0, bus.busy}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      init_val[i] = $urandom;
      do_txn(1'b1, 2'b10, 1'b0, BASE + 32'(4*i), init_val[i], rd, e);
    end

    // Directed: word store/load and latency.
    do_txn(1'b1, 2'b10, 1'b0, BASE + 32'h4, 32'hDEADBEEF, rd, e);
    lat_chk = resp_edge - acc_edge + 1;
    chk("sw latency", 32'(lat_chk), 32'd4);
    do_txn(1'b0, 2'b10, 1'b0, BASE + 32'h4, 32'h0, rd, e);
    chk("t1 model lw", rd, 32'hDEADBEEF);
    chk("t1 dut lw", bus.rdata, 32'hDEADBEEF);
    chk("t1 ready", {31'b0, bus.ready}, 32'h1);

    do_txn(1'b1, 2'b00, 1'b0, BASE + 32'h5, 32'h11, rd, e);
    do_txn(1'b0, 2'b10, 1'b0, BASE + 32'h4, 32'h0, rd, e);
    chk("t2 sb merge", bus.rdata, 32'hDEAD11EF);
    do_txn(1'b1, 2'b01, 1'b0, BASE + 32'h6, 32'h2233, rd, e);
    do_txn(1'b0, 2'b10, 1'b0, BASE + 32'h4, 32'h0, rd, e);
    chk("t2 sh merge", bus.rdata, 32'h223311EF);

    do_txn(1'b1, 2'b10, 1'b0, BASE + 32'h8, 32'h00008080, rd, e);
    do_txn(1'b0, 2'b00, 1'b1, BASE + 32'h8, 32'h0, rd, e);
    chk("t3 lb", bus.rdata, 32'hFFFFFF80);
    do_txn(1'b0, 2'b00, 1'b0, BASE + 32'h8, 32'h0, rd, e);
    chk("t3 lbu", bus.rdata, 32'h00000080);
    do_txn(1'b0, 2'b01, 1'b1, BASE + 32'h8, 32'h0, rd, e);
    chk("t3 lh", bus.rdata, 32'hFFFF8080);
    do_txn(1'b0, 2'b01, 1'b0, BASE + 32'h8, 32'h0, rd, e);
    chk("t3 lhu", bus.rdata, 32'h00008080);

    // Rejected accesses: one-edge latency, no store, rdata held.
    do_txn(1'b0, 2'b10, 1'b0, BASE + 32'h2, 32'h0, rd, e);
    chk("t4 misaligned lw", {31'b0, e}, 32'h1);
    do_txn(1'b1, 2'b01, 1'b0, BASE + 32'h1, 32'hAAAA, rd, e);
    chk("t4 misaligned sh", {31'b0, bus.err}, 32'h1);
    do_txn(1'b1, 2'b11, 1'b0, BASE, 32'hFFFFFFFF, rd, e);
    chk("t4 size11", {31'b0, bus.err}, 32'h1);
    do_txn(1'b0, 2'b10, 1'b0, 32'h10012000, 32'h0, rd, e);
    chk("t4 above range", {31'b0, bus.err}, 32'h1);
    do_txn(1'b0, 2'b10, 1'b0, 32'h1000FFFC, 32'h0, rd, e);
    chk("t4 below range", {31'b0, bus.err}, 32'h1);
    chk("t4 rdata held", bus.rdata, 32'h00008080);
    do_txn(1'b0, 2'b10, 1'b0, BASE, 32'h0, rd, e);
    chk("t4 mem unchanged", bus.rdata, init_val[0]);

    do_txn(1'b1, 2'b10, 1'b0, 32'h10011FFC, 32'hCAFEF00D, rd, e);
    do_txn(1'b0, 2'b10, 1'b0, 32'h10011FFC, 32'h0, rd, e);
    chk("last word", bus.rdata, 32'hCAFEF00D);

    // Reset during WAIT drops the store.
    idle(1);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.sign_ext = 1'b0;
    bus.addr = BASE + 32'h10; bus.wdata = 32'h12345678;
    @(posedge clk); #1;
    rd_before = rd_after; txn_err = 1'b0;
    acc_edge = cyc; resp_edge = cyc + WAIT + 1;
    @(negedge clk);
    bus.req = 1'b0;
    #2 rst = 1'b1;
    acc_edge = -1; resp_edge = -1; rd_before = '0; rd_after = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    do_txn(1'b0, 2'b10, 1'b0, BASE + 32'h10, 32'h0, rd, e);
    chk("t5 store dropped", bus.rdata, init_val[4]);

    // Randomized traffic, random gaps (zero gap = back-to-back accept in RESP).
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 9))
        0:       a = BASE - 32'd1 - 32'($urandom_range(0, 64));
        1:       a = BASE + 32'd8192 + 32'($urandom_range(0, 64));
        default: a = BASE + 32'($urandom_range(0, 63));
      endcase
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, rd, e);
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);

    // Zero-wait instance: req held high through RESP, busy never drops.
    @(negedge clk);
    bus0.req = 1'b1; bus0.we = 1'b1; bus0.size = 2'b10; bus0.sign_ext = 1'b0;
    bus0.addr = BASE + 32'h20; bus0.wdata = 32'h11111111;
    @(negedge clk);
    chk("t6 c1 ready", {31'b0, bus0.ready}, 32'h0);
    chk("t6 c1 busy",  {31'b0, bus0.busy},  32'h1);
    bus0.wdata = 32'h22222222;
    @(negedge clk);
    chk("t6 c2 ready", {31'b0, bus0.ready}, 32'h1);
    chk("t6 c2 err",   {31'b0, bus0.err},   32'h0);
    @(negedge clk);
    chk("t6 c3 ready", {31'b0, bus0.ready}, 32'h0);
    chk("t6 c3 busy",  {31'b0, bus0.busy},  32'h1);
    bus0.we = 1'b0;
    @(negedge clk);
    chk("t6 c4 ready", {31'b0, bus0.ready}, 32'h1);
    chk("t6 c4 busy",  {31'b0, bus0.busy},  32'h1);
    @(negedge clk);
    chk("t6 c5 ready", {31'b0, bus0.ready}, 32'h0);
    chk("t6 c5 busy",  {31'b0, bus0.busy},  32'h1);
    bus0.req = 1'b0;
    @(negedge clk);
    chk("t6 c6 ready", {31'b0, bus0.ready}, 32'h1);
    chk("t6 c6 rdata", bus0.rdata, 32'h22222222);
    @(negedge clk);
    chk("t6 c7 busy",  {31'b0, bus0.busy},  32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
